// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer that drives the ALU, register file,
// data memory strobes and PC update. Outputs are registered from the next state.
module instr_sequencer #(
    parameter int unsigned WORD_W       = 16,
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] instr,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic [2:0]        flags,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [3:0]        alu_opcode,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    output logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] imm,
    output logic              alu_src_imm,
    output logic              reg_wen,
    output logic [1:0]        wb_sel,
    output logic              byte_hi,
    output logic              pc_wen,
    output logic [1:0]        pc_sel,
    output logic [WORD_W-1:0] branch_off,
    output logic              halted,
    output logic              err
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W:0]    wait_inc;
    logic              wait_hit;
    logic              err_d;
    logic              take_d;
    logic [3:0]        op_q, op_n;
    logic              pc_wen_q;
    logic              sw_retire_c;

    logic              imem_req_d, dmem_req_d, dmem_wr_d, alu_src_imm_d;
    logic              reg_wen_d, byte_hi_d, pc_wen_d, halted_d;
    logic [3:0]        alu_opcode_d, rs_addr_d, rt_addr_d, rd_addr_d;
    logic [1:0]        wb_sel_d, pc_sel_d;
    logic [WORD_W-1:0] imm_d, branch_off_d;

    // Flags are {V,N,Z}
    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        logic v, n, z, r;
        v = f[2];
        n = f[1];
        z = f[0];
        case (ccc)
            3'b000:  r = !z;
            3'b001:  r = z;
            3'b010:  r = !z && !n;
            3'b011:  r = n;
            3'b100:  r = z || (!z && !n);
            3'b101:  r = n || z;
            3'b110:  r = v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign op_q        = ir_q[15:12];
    assign op_n        = ir_d[15:12];
    assign wait_inc    = {1'b0, wait_q} + (CNT_W + 1)'(1);
    assign wait_hit    = (MEM_WAIT_MAX != 0) && (wait_inc == (CNT_W + 1)'(MEM_WAIT_MAX));
    // A store retires in the cycle its data handshake completes
    assign sw_retire_c = (state_q == S_MEM) && dmem_ready && (op_q == OP_SW);
    assign pc_wen      = pc_wen_q | sw_retire_c;

    // Next-state, instruction capture and wait counter
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = '0;
        err_d   = err;
        take_d  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_req) begin
                    if (imem_ready) begin
                        ir_d    = instr;
                        state_d = S_DECODE;
                    end else if (wait_hit) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_inc[CNT_W-1:0];
                    end
                end
            end
            S_DECODE: begin
                state_d = (op_q == OP_HLT) ? S_HALT : S_EXEC;
                take_d  = cond_met(ir_q[11:9], flags);
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_B, OP_BR:  state_d = S_FETCH;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc[CNT_W-1:0];
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        imem_req_d    = 1'b0;
        dmem_req_d    = 1'b0;
        dmem_wr_d     = 1'b0;
        alu_opcode_d  = 4'h0;
        rs_addr_d     = 4'h0;
        rt_addr_d     = 4'h0;
        rd_addr_d     = 4'h0;
        imm_d         = '0;
        alu_src_imm_d = 1'b0;
        reg_wen_d     = 1'b0;
        wb_sel_d      = 2'b00;
        byte_hi_d     = 1'b0;
        pc_wen_d      = 1'b0;
        pc_sel_d      = 2'b00;
        branch_off_d  = '0;
        halted_d      = 1'b0;
        case (state_d)
            S_FETCH: imem_req_d = 1'b1;
            S_HALT:  halted_d   = 1'b1;
            default: begin
                alu_opcode_d = op_n;
                rd_addr_d    = ir_d[11:8];
                rs_addr_d    = ir_d[7:4];
                rt_addr_d    = ir_d[3:0];
                case (op_n)
                    OP_SLL, OP_SRA, OP_ROR: begin
                        imm_d         = WORD_W'(ir_d[3:0]);
                        alu_src_imm_d = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        rt_addr_d     = ir_d[11:8];
                        imm_d         = WORD_W'($signed(ir_d[3:0]));
                        alu_src_imm_d = 1'b1;
                        wb_sel_d      = (op_n == OP_LW) ? 2'b01 : 2'b00;
                    end
                    OP_LLB, OP_LHB: begin
                        rs_addr_d = ir_d[11:8];
                        imm_d     = WORD_W'(ir_d[7:0]);
                        wb_sel_d  = 2'b11;
                        byte_hi_d = op_n[0];
                    end
                    OP_B:    branch_off_d = WORD_W'($signed({ir_d[8:0], 1'b0}));
                    OP_PCS:  wb_sel_d = 2'b10;
                    default: ;
                endcase
                if (state_d == S_MEM) begin
                    dmem_req_d = 1'b1;
                    dmem_wr_d  = (op_n == OP_SW);
                end
                if (state_d == S_WB) begin
                    reg_wen_d = 1'b1;
                    pc_wen_d  = 1'b1;
                end
                if (state_d == S_EXEC && (op_n == OP_B || op_n == OP_BR)) begin
                    pc_wen_d = 1'b1;
                    if (take_d) begin
                        pc_sel_d = (op_n == OP_B) ? 2'b01 : 2'b10;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            wait_q      <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_wr     <= 1'b0;
            alu_opcode  <= 4'h0;
            rs_addr     <= 4'h0;
            rt_addr     <= 4'h0;
            rd_addr     <= 4'h0;
            imm         <= '0;
            alu_src_imm <= 1'b0;
            reg_wen     <= 1'b0;
            wb_sel      <= 2'b00;
            byte_hi     <= 1'b0;
            pc_wen_q    <= 1'b0;
            pc_sel      <= 2'b00;
            branch_off  <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            imem_req    <= imem_req_d;
            dmem_req    <= dmem_req_d;
            dmem_wr     <= dmem_wr_d;
            alu_opcode  <= alu_opcode_d;
            rs_addr     <= rs_addr_d;
            rt_addr     <= rt_addr_d;
            rd_addr     <= rd_addr_d;
            imm         <= imm_d;
            alu_src_imm <= alu_src_imm_d;
            reg_wen     <= reg_wen_d;
            wb_sel      <= wb_sel_d;
            byte_hi     <= byte_hi_d;
            pc_wen_q    <= pc_wen_d;
            pc_sel      <= pc_sel_d;
            branch_off  <= branch_off_d;
            halted      <= halted_d;
            err         <= err_d;
        end
    end

endmodule
